// File: rtl/nonce_hub_arbiter.sv
// Collects golden-nonce pulses from SLAVES sources, arbitrates them round-robin into a FIFO and
// feeds the serial transmitter. FSM: IDLE wait for data | SEND strobe | WAIT_BUSY (4-cycle timeout) | WAIT_DONE.
module nonce_hub_arbiter #(
  parameter int SLAVES     = 4,
  parameter int DEPTH_LOG2 = 3,
  parameter int TAG_MODE   = 0,
  parameter int TAG_BITS   = 2
) (
  input  logic                   hash_clk,
  input  logic                   reset_n,
  input  logic [SLAVES*32-1:0]   slave_nonces,
  input  logic [SLAVES-1:0]      new_nonces,
  input  logic                   serial_busy,
  output logic                   serial_send,
  output logic [31:0]            golden_nonce,
  output logic [DEPTH_LOG2:0]    fifo_level,
  output logic [15:0]            dropped_count,
  output logic                   overflow,
  input  logic                   clear_stats
);

  localparam int PW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_BUSY, S_WAIT_DONE} state_e;

  logic [31:0]           hold_q [SLAVES];
  logic [31:0]           hold_d [SLAVES];
  logic [SLAVES-1:0]     pend_q, pend_d;
  logic [PW-1:0]         rr_q, rr_d;
  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [15:0]           drop_q, drop_d;
  logic                  ovf_q, ovf_d;
  logic [4:0]            n_drops;
  logic [16:0]           drop_sum;
  logic                  grant, pop;
  logic [PW-1:0]         gidx;
  int                    k;

  state_e      state_q;
  logic        send_q;
  logic [31:0] golden_q;
  logic [1:0]  wait_q;

  function automatic logic [31:0] tag_nonce(input logic [31:0] n, input int idx);
    logic [31:0] r;
    r = n;
    if (TAG_MODE != 0) r[31 -: TAG_BITS] = TAG_BITS'(idx);
    return r;
  endfunction

  assign pop = (state_q == S_IDLE) && (level_q != '0) && !serial_busy;

  always_comb begin
    grant = 1'b0;
    gidx  = '0;
    k     = 0;
    for (int j = 0; j < SLAVES; j++) begin
      k = (int'(rr_q) + j) % SLAVES;
      if (!grant && (level_q != FULL) && pend_q[k]) begin
        grant = 1'b1;
        gidx  = PW'(k);
      end
    end
    rr_d = rr_q;
    if (grant) rr_d = (gidx == PW'(SLAVES - 1)) ? '0 : gidx + PW'(1);
  end

  // A slave granted this cycle frees its holding register, so a coincident new nonce is not a drop.
  always_comb begin
    pend_d  = pend_q;
    hold_d  = hold_q;
    n_drops = '0;
    if (grant) pend_d[gidx] = 1'b0;
    for (int i = 0; i < SLAVES; i++) begin
      if (new_nonces[i]) begin
        if (!pend_q[i] || (grant && (gidx == PW'(i)))) begin
          hold_d[i] = tag_nonce(slave_nonces[i*32 +: 32], i);
          pend_d[i] = 1'b1;
        end else begin
          n_drops = n_drops + 5'd1;
        end
      end
    end
  end

  always_comb begin
    drop_sum = {1'b0, (clear_stats ? 16'd0 : drop_q)} + 17'(n_drops);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    ovf_d    = (clear_stats ? 1'b0 : ovf_q) | (n_drops != '0);
    wr_d     = grant ? wr_q + 1'b1 : wr_q;
    rd_d     = pop ? rd_q + 1'b1 : rd_q;
    level_d  = level_q;
    case ({grant, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge hash_clk) begin
    if (!reset_n) begin
      hold_q  <= '{default: '0};
      pend_q  <= '0;
      rr_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge hash_clk) begin
    if (grant) mem_q[wr_q] <= hold_q[gidx];
  end

  always_ff @(posedge hash_clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      send_q   <= 1'b0;
      golden_q <= '0;
      wait_q   <= '0;
    end else begin
      send_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            golden_q <= mem_q[rd_q];
            send_q   <= 1'b1;
            state_q  <= S_SEND;
          end
        end
        S_SEND: begin
          wait_q  <= 2'd3;
          state_q <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (serial_busy)          state_q <= S_WAIT_DONE;
          else if (wait_q == 2'd0)  state_q <= S_IDLE;
          else                      wait_q  <= wait_q - 2'd1;
        end
        S_WAIT_DONE: begin
          if (!serial_busy) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign serial_send   = send_q;
  assign golden_nonce  = golden_q;
  assign fifo_level    = level_q;
  assign dropped_count = drop_q;
  assign overflow      = ovf_q;

endmodule

// File: doc/nonce_hub_arbiter.md
Name: nonce_hub_arbiter

Overview:
- Parametrised successor to the cluster hub's nonce-return path.
- Accepts golden-nonce pulses from SLAVES miners (local or serial-port slaves) into per-slave holding registers and arbitrates them round-robin into a DEPTH-entry FIFO.
- Feeds the FIFO to the 32-bit serial transmitter through a send/busy handshake.
- Optionally tags each nonce with its slave index; counts dropped nonces.

Parameters:
- SLAVES, 4, number of nonce sources (1..16).
- DEPTH_LOG2, 3, FIFO holds 2**DEPTH_LOG2 entries.
- TAG_MODE, 0, 0 = send raw nonce; 1 = overwrite nonce[31:32-TAG_BITS] with slave index.
- TAG_BITS, 2, tag width; must satisfy 2**TAG_BITS >= SLAVES when TAG_MODE = 1.

Ports:
- hash_clk  in  1  single clock for all logic.
- reset_n  in  1  synchronous, active-low reset.
- slave_nonces  in  SLAVES*32  slave i nonce on bits [i*32+31:i*32].
- new_nonces  in  SLAVES  bit i high for one cycle = slave i nonce valid that cycle.
- serial_busy  in  1  transmitter busy.
- serial_send  out  1  one-cycle send strobe to transmitter.
- golden_nonce  out  32  word to transmit; stable from the send strobe until the next send.
- fifo_level  out  DEPTH_LOG2+1  current FIFO occupancy.
- dropped_count  out  16  saturating count of lost nonces.
- overflow  out  1  sticky; set on first drop.
- clear_stats  in  1  synchronous clear of dropped_count and overflow.

Behaviour:
- Reset (reset_n = 0 at a hash_clk edge): all holding registers empty, FIFO empty, rr_ptr = 0, FSM = IDLE, serial_send = 0, golden_nonce = 0, fifo_level = 0, dropped_count = 0, overflow = 0. Reset mid-transmission discards FIFO and pending contents with no further send. The transmitter finishes its current word on its own.
- Capture:
  - new_nonces[i] = 1 with hold[i] empty: load the nonce (tagged if TAG_MODE = 1), set pend[i].
  - new_nonces[i] = 1 with pend[i] set and slave i not granted this cycle: the new nonce is dropped; the old nonce is kept.
  - If slave i is granted in the same cycle, the new nonce is loaded and no drop occurs.
- Arbitration:
  - At most one grant per cycle, only when the FIFO is not full.
  - Search order is rr_ptr, rr_ptr+1, …, wrapping modulo SLAVES. The first set pend[k] is granted.
  - On a grant, hold[k] is pushed, pend[k] is cleared, and rr_ptr becomes (k+1) mod SLAVES.
  - With no grant, rr_ptr is unchanged.
  - Latency from new_nonces pulse to FIFO entry is 1 cycle minimum.
- FIFO:
  - Synchronous circular buffer with a DEPTH_LOG2+1-bit level.
  - Push and pop in the same cycle leave the level unchanged; this is legal when full, since the pop frees the slot.
  - Push is never issued when full without a same-cycle pop.
  - Pop on empty is never issued.
- Drop accounting:
  - Each dropped nonce increments dropped_count by 1, saturating at 16'hFFFF, and sets overflow.
  - Multiple slaves dropping in one cycle add the number of drops, saturating.
  - When clear_stats and a drop occur in the same cycle, the result is count = number of new drops and overflow = 1.
- Transmit FSM, states IDLE, SEND, WAIT_BUSY, WAIT_DONE:
  - IDLE: when the FIFO is non-empty and serial_busy = 0, register golden_nonce = head, pop, and go to SEND.
  - SEND: serial_send = 1 for exactly this cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: wait until serial_busy = 1, then go to WAIT_DONE. If serial_busy = 1 is never seen within 4 cycles, go to IDLE anyway.
  - WAIT_DONE: wait until serial_busy = 0, then go to IDLE.
  - Minimum spacing between send strobes is 4 cycles plus the transmitter busy time.
  - serial_send is never asserted outside SEND.

Test Plan:
- Reset with all inputs idle → serial_send = 0, golden_nonce = 0, fifo_level = 0, dropped_count = 0 for 100 cycles.
- SLAVES = 4, TAG_MODE = 0: slave 2 pulses nonce 32'hDEADBEEF; transmitter model with busy = 1 for 20 cycles → one serial_send strobe with golden_nonce = 32'hDEADBEEF; fifo_level returns to 0.
- Simultaneous pulse on all 4 slaves (nonces 0x11, 0x22, 0x33, 0x44), rr_ptr = 0 → transmit order 0x11, 0x22, 0x33, 0x44. A repeat burst with rr_ptr starting at 1 gives order 0x22, 0x33, 0x44, 0x11.
- TAG_MODE = 1, TAG_BITS = 2: slave 3 sends 32'h0000_1234 → golden_nonce = 32'hC000_1234.
- Hold serial_busy = 1 permanently; slave 0 pulses 12 times, one every 2 cycles, with DEPTH_LOG2 = 3 → fifo_level = 8, one nonce pending in hold, dropped_count = 3, overflow = 1. A later clear_stats pulse → dropped_count = 0, overflow = 0.
- Assert reset_n = 0 for 1 cycle while in WAIT_DONE with 5 entries queued → no further serial_send after busy drops; fifo_level = 0 on the next cycle.
